hs32_regfile: RTL and testbench

Parametrised, mode-banked register file for the hs32 core, replacing the fixed 16×32 single-mode file. Two registered read ports and one write port run concurrently on the rising edge, with optional write-to-read bypass. The top registers are banked between user and supervisor mode, with explicit user-bank access for supervisor save/restore. A post-reset clear sequencer zeroes every physical entry before the core may issue.

---
 rtl/hs32_regfile_pkg.sv | 12 +
 rtl/hs32_regfile_map.sv | 15 +
 rtl/hs32_regfile.sv | 58 +++++
 tb/tb_hs32_regfile.sv | 115 +++++++++++
 4 files changed

// File: rtl/hs32_regfile_pkg.sv
// hs32_regfile_pkg: mode constants, sequencer states and logical-to-physical mapping
package hs32_regfile_pkg;
  localparam logic MODE_USER = 1'b0;
  localparam logic MODE_SUPV = 1'b1;
  typedef enum logic {CLEAR, RUN} state_t;
  function automatic int unsigned phys_idx(input int unsigned adr, input logic mode, input logic usr,
                                           input int unsigned aw, input int unsigned banked);
    int unsigned logical;
    logical = 32'd1 << aw;
    return (adr >= logical - banked && (mode & ~usr)) ? logical + adr - (logical - banked) : adr;
  endfunction
endpackage

// File: rtl/hs32_regfile_map.sv
// hs32_regfile_map: combinational logical-to-physical register index (adr, mode, usr -> idx)
module hs32_regfile_map
  import hs32_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int BANKED = 4,
  parameter int PW = 5
) (
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic                  mode,
  input  logic                  usr,
  output logic [PW-1:0]         idx
);
  assign idx = PW'(phys_idx(32'(adr), mode, usr, ADDR_WIDTH, BANKED));
endmodule

// File: rtl/hs32_regfile.sv
// hs32_regfile: mode-banked 2R1W register file with post-reset clear (clk, reset, ready, mode, we/wadr/wusr/din, radrN/rusrN -> doutN)
module hs32_regfile
  import hs32_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BANKED = 4,
  parameter bit BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  mode,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wadr,
  input  logic                  wusr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] radr1,
  input  logic                  rusr1,
  input  logic [ADDR_WIDTH-1:0] radr2,
  input  logic                  rusr2,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] dout2
);
  localparam int LOGICAL = 2 ** ADDR_WIDTH;
  localparam int PHYS = LOGICAL + BANKED;
  localparam int PW = $clog2(PHYS);
  localparam int CW = PW + 1;
  logic [DATA_WIDTH-1:0] mem [PHYS];
  state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] widx, ridx1, ridx2;
  hs32_regfile_map #(.ADDR_WIDTH(ADDR_WIDTH), .BANKED(BANKED), .PW(PW)) u_wmap (.adr(wadr), .mode(mode), .usr(wusr), .idx(widx));
  hs32_regfile_map #(.ADDR_WIDTH(ADDR_WIDTH), .BANKED(BANKED), .PW(PW)) u_rmap1 (.adr(radr1), .mode(mode), .usr(rusr1), .idx(ridx1));
  hs32_regfile_map #(.ADDR_WIDTH(ADDR_WIDTH), .BANKED(BANKED), .PW(PW)) u_rmap2 (.adr(radr2), .mode(mode), .usr(rusr2), .idx(ridx2));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
      dout1 <= '0;
      dout2 <= '0;
    end else if (state == CLEAR) begin
      mem[cnt[PW-1:0]] <= '0;
      cnt   <= cnt + 1'b1;
      dout1 <= '0;
      dout2 <= '0;
      if (cnt == CW'(PHYS - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else begin
      if (we) mem[widx] <= din;
      dout1 <= (BYPASS && we && widx == ridx1) ? din : mem[ridx1];
      dout2 <= (BYPASS && we && widx == ridx2) ? din : mem[ridx2];
    end
  end
endmodule

// File: tb/tb_hs32_regfile.sv
// tb_hs32_regfile: directed checks of clear, banking, user override, bypass and mid-clear reset
module tb_hs32_regfile;
  logic clk = 1'b0;
  logic reset, mode, we, wusr, rusr1, rusr2;
  logic [3:0] wadr, radr1, radr2;
  logic [31:0] din, dout1_b, dout2_b, dout1_n, dout2_n;
  logic ready_b, ready_n;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hs32_regfile #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .ready(ready_b), .mode(mode), .we(we), .wadr(wadr), .wusr(wusr), .din(din),
    .radr1(radr1), .rusr1(rusr1), .radr2(radr2), .rusr2(rusr2), .dout1(dout1_b), .dout2(dout2_b)
  );
  hs32_regfile #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .ready(ready_n), .mode(mode), .we(we), .wadr(wadr), .wusr(wusr), .din(din),
    .radr1(radr1), .rusr1(rusr1), .radr2(radr2), .rusr2(rusr2), .dout1(dout1_n), .dout2(dout2_n)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic m, input logic [3:0] a, input logic u, input logic [31:0] d);
    mode = m; wadr = a; wusr = u; din = d; we = 1'b1;
    tick();
    we = 1'b0; wusr = 1'b0;
  endtask
  task automatic rd(input logic m, input logic [3:0] a, input logic u);
    mode = m; radr1 = a; rusr1 = u; radr2 = a; rusr2 = u;
    tick();
  endtask
  task automatic expect_rd(input string tag, input logic m, input logic [3:0] a, input logic u, input logic [31:0] exp);
    rd(m, a, u);
    check({tag, "_b1"}, dout1_b, exp);
    check({tag, "_b2"}, dout2_b, exp);
    check({tag, "_n1"}, dout1_n, exp);
  endtask
  task automatic clear_seq(input string tag);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check({tag, "_ready_b"}, 32'(ready_b), 32'(i == 20));
      check({tag, "_ready_n"}, 32'(ready_n), 32'(i == 20));
      if (i < 20) check({tag, "_dout_clr"}, dout1_b, 32'h0);
    end
  endtask
  task automatic all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      expect_rd({tag, "_usr"}, 1'b0, 4'(a), 1'b0, 32'h0);
      expect_rd({tag, "_sup"}, 1'b1, 4'(a), 1'b0, 32'h0);
    end
  endtask
  initial begin
    reset = 1'b1; mode = 1'b0; we = 1'b0; wusr = 1'b0; rusr1 = 1'b0; rusr2 = 1'b0;
    wadr = '0; radr1 = '0; radr2 = '0; din = '0;
    tick();
    check("reset_ready", 32'(ready_b), 32'h0);
    check("reset_dout", dout1_b, 32'h0);
    reset = 1'b0;
    clear_seq("clr");
    all_zero("clr_rd");
    wr(1'b0, 4'd14, 1'b0, 32'hAAAA0001);
    wr(1'b1, 4'd14, 1'b0, 32'h55550002);
    wr(1'b1, 4'd3, 1'b0, 32'h00000033);
    expect_rd("bank_u14", 1'b0, 4'd14, 1'b0, 32'hAAAA0001);
    expect_rd("bank_u3", 1'b0, 4'd3, 1'b0, 32'h00000033);
    expect_rd("bank_s14", 1'b1, 4'd14, 1'b0, 32'h55550002);
    expect_rd("bank_s3", 1'b1, 4'd3, 1'b0, 32'h00000033);
    expect_rd("bank_s14_rusr", 1'b1, 4'd14, 1'b1, 32'hAAAA0001);
    wr(1'b1, 4'd13, 1'b1, 32'h00001234);
    expect_rd("wusr_u13", 1'b0, 4'd13, 1'b0, 32'h00001234);
    expect_rd("wusr_s13_rusr", 1'b1, 4'd13, 1'b1, 32'h00001234);
    expect_rd("wusr_s13", 1'b1, 4'd13, 1'b0, 32'h0);
    wr(1'b0, 4'd5, 1'b0, 32'h10);
    mode = 1'b0; wadr = 4'd5; din = 32'h20; we = 1'b1;
    radr1 = 4'd5; radr2 = 4'd5; rusr1 = 1'b0; rusr2 = 1'b0;
    tick();
    we = 1'b0;
    check("byp_b1", dout1_b, 32'h20);
    check("byp_b2", dout2_b, 32'h20);
    check("byp_n1", dout1_n, 32'h10);
    check("byp_n2", dout2_n, 32'h10);
    tick();
    check("byp_n1_next", dout1_n, 32'h20);
    check("byp_n2_next", dout2_n, 32'h20);
    wr(1'b1, 4'd15, 1'b0, 32'h77);
    mode = 1'b1; wadr = 4'd15; wusr = 1'b1; din = 32'h99; we = 1'b1;
    radr1 = 4'd15; rusr1 = 1'b0; radr2 = 4'd15; rusr2 = 1'b1;
    tick();
    we = 1'b0; wusr = 1'b0;
    check("xbank_b1", dout1_b, 32'h77);
    check("xbank_b2_usr", dout2_b, 32'h99);
    check("xbank_n1", dout1_n, 32'h77);
    expect_rd("xbank_u15", 1'b0, 4'd15, 1'b0, 32'h99);
    expect_rd("xbank_s15", 1'b1, 4'd15, 1'b0, 32'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("midclr_ready", 32'(ready_b), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_seq("mid");
    all_zero("mid_rd");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
